// File: rtl/regfile_spec_pkg.sv
// Shared types and helpers for the register-file speculation controller.
package regfile_spec_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPEC    = 2'd1,
        RESTORE = 2'd2
    } specState_t;

    function automatic int addrWidth(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/regfile_onehot_decode.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled.
module regfile_onehot_decode #(
    parameter int REGCOUNT     = 16,
    parameter int REGADDRWIDTH = 4
) (
    input  logic                    en,
    input  logic [REGADDRWIDTH-1:0] addr,
    output logic [REGCOUNT-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_spec_controller.sv
// Tracks one outstanding speculative branch and drives shadow-capture,
// commit and restore controls for the register-file cell array.
module regfile_spec_controller
    import regfile_spec_pkg::*;
#(
    parameter int REGCOUNT          = 16,
    parameter int REGADDRWIDTH      = addrWidth(REGCOUNT),
    parameter bit ZEROREG_HARDWIRED = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic                    BranchIssueValid,
    output logic                    BranchIssueReady,
    input  logic                    BranchResolveValid,
    input  logic                    BranchResolveMispredict,
    input  logic                    WriteIssueValid,
    input  logic [REGADDRWIDTH-1:0] WriteIssueAddr,
    output logic                    IssueStall,
    output logic                    Speculating,
    output logic [REGCOUNT-1:0]     WillBeWritingTo,
    output logic                    EndSpeculationPulse,
    output logic                    MispredictedSpeculationPulse,
    output logic [REGCOUNT-1:0]     ShadowMask,
    output logic [REGADDRWIDTH:0]   ShadowCount
);

    localparam logic [REGADDRWIDTH:0] COUNT_ONE = 1;

    specState_t              state, nextState;
    logic [REGCOUNT-1:0]     nextMask;
    logic [REGADDRWIDTH:0]   nextCount;
    logic                    captureEn;
    logic [REGCOUNT-1:0]     captureVec;
    logic                    resolving;

    // A write is shadowed only inside an open window, before resolution,
    // and only the first time its register is touched in that window.
    always_comb begin
        resolving = clk_en && (state == SPEC) && BranchResolveValid;
        captureEn = clk_en && (state == SPEC) && WriteIssueValid
                    && !BranchResolveValid
                    && !ShadowMask[WriteIssueAddr]
                    && !(ZEROREG_HARDWIRED && (WriteIssueAddr == '0));
    end

    regfile_onehot_decode #(
        .REGCOUNT    (REGCOUNT),
        .REGADDRWIDTH(REGADDRWIDTH)
    ) captureDecode (
        .en    (captureEn),
        .addr  (WriteIssueAddr),
        .onehot(captureVec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ShadowMask  <= '0;
            ShadowCount <= '0;
        end else if (clk_en) begin
            state       <= nextState;
            ShadowMask  <= nextMask;
            ShadowCount <= nextCount;
        end
    end

    always_comb begin
        nextState                    = state;
        nextMask                     = ShadowMask;
        nextCount                    = ShadowCount;
        BranchIssueReady             = 1'b0;
        IssueStall                   = 1'b0;
        Speculating                  = 1'b0;
        WillBeWritingTo              = captureVec;
        EndSpeculationPulse          = 1'b0;
        MispredictedSpeculationPulse = 1'b0;

        unique case (state)
            IDLE: begin
                BranchIssueReady = 1'b1;
                if (BranchIssueValid) begin
                    nextState = SPEC;
                    nextMask  = '0;
                    nextCount = '0;
                end
            end
            SPEC: begin
                Speculating = 1'b1;
                if (resolving && !BranchResolveMispredict) begin
                    EndSpeculationPulse = 1'b1;
                    nextState           = IDLE;
                    nextMask            = '0;
                    nextCount           = '0;
                end else if (resolving) begin
                    IssueStall = 1'b1;
                    nextState  = RESTORE;
                end else if (captureEn) begin
                    nextMask  = ShadowMask | captureVec;
                    nextCount = ShadowCount + COUNT_ONE;
                end
            end
            RESTORE: begin
                // The mask survives this cycle so cells know which shadows to restore.
                IssueStall                   = 1'b1;
                MispredictedSpeculationPulse = clk_en;
                nextState                    = IDLE;
                nextMask                     = '0;
                nextCount                    = '0;
            end
            default: begin
                nextState = IDLE;
                nextMask  = '0;
                nextCount = '0;
            end
        endcase
    end

endmodule
